// File: rtl/misr_sig_checker.sv
// Self-test window sequencer: seeds two MISRs, lets them compact for WINDOW cycles,
// then grades the captured signatures against golden values and tallies fails/escapes.
module misr_sig_checker #(
  parameter int unsigned      SIG_W  = 3,
  parameter int unsigned      WINDOW = 5,
  parameter logic [SIG_W-1:0] GOLD_A = 3'b001,
  parameter logic [SIG_W-1:0] GOLD_B = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIG_W-1:0] sig_a,
  input  logic [SIG_W-1:0] sig_b,
  input  logic             inj_flag,
  output logic             misr_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch_a,
  output logic             mismatch_b,
  output logic             err_seen,
  output logic             escape,
  output logic [7:0]       fail_cnt,
  output logic [7:0]       esc_cnt
);

  typedef enum logic [2:0] {StIdle, StSeed, StRun, StCheck, StDone} state_e;

  localparam logic [7:0] LastCyc = 8'(WINDOW - 1);

  state_e     state_q, state_d;
  logic [7:0] cyc_cnt_q, cyc_cnt_d;
  logic       misr_rst_q, misr_rst_d;
  logic       err_seen_q, err_seen_d;
  logic       pass_q, pass_d;
  logic       mismatch_a_q, mismatch_a_d;
  logic       mismatch_b_q, mismatch_b_d;
  logic       escape_q, escape_d;
  logic [7:0] fail_cnt_q, fail_cnt_d;
  logic [7:0] esc_cnt_q, esc_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cyc_cnt_q    <= '0;
      misr_rst_q   <= 1'b0;
      err_seen_q   <= 1'b0;
      pass_q       <= 1'b0;
      mismatch_a_q <= 1'b0;
      mismatch_b_q <= 1'b0;
      escape_q     <= 1'b0;
      fail_cnt_q   <= '0;
      esc_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      misr_rst_q   <= misr_rst_d;
      err_seen_q   <= err_seen_d;
      pass_q       <= pass_d;
      mismatch_a_q <= mismatch_a_d;
      mismatch_b_q <= mismatch_b_d;
      escape_q     <= escape_d;
      fail_cnt_q   <= fail_cnt_d;
      esc_cnt_q    <= esc_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSeed;
      StSeed:  state_d = StRun;
      StRun:   if (cyc_cnt_q == LastCyc) state_d = StCheck;
      StCheck: state_d = StDone;
      StDone:  if (start) state_d = StSeed;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cyc_cnt_d    = cyc_cnt_q;
    err_seen_d   = err_seen_q;
    pass_d       = pass_q;
    mismatch_a_d = mismatch_a_q;
    mismatch_b_d = mismatch_b_q;
    escape_d     = escape_q;
    fail_cnt_d   = fail_cnt_q;
    esc_cnt_d    = esc_cnt_q;
    // Registered so the seed pulse lines up exactly with the SEED cycle.
    misr_rst_d   = (state_d == StSeed);
    unique case (state_q)
      StIdle, StDone: begin
        // Results clear on entry so they already read 0 during SEED.
        if (start) begin
          cyc_cnt_d    = '0;
          err_seen_d   = 1'b0;
          pass_d       = 1'b0;
          mismatch_a_d = 1'b0;
          mismatch_b_d = 1'b0;
          escape_d     = 1'b0;
        end
      end
      StSeed: begin
        cyc_cnt_d  = '0;
        err_seen_d = err_seen_q | inj_flag;
      end
      StRun: begin
        cyc_cnt_d  = cyc_cnt_q + 8'd1;
        err_seen_d = err_seen_q | inj_flag;
      end
      StCheck: begin
        mismatch_a_d = (sig_a != GOLD_A);
        mismatch_b_d = (sig_b != GOLD_B);
        pass_d       = !mismatch_a_d && !mismatch_b_d;
        escape_d     = err_seen_q && pass_d;
        if (!pass_d && fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
        if (escape_d && esc_cnt_q != 8'hFF) esc_cnt_d = esc_cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy       = (state_q == StSeed) || (state_q == StRun) || (state_q == StCheck);
    done       = (state_q == StDone);
    misr_rst   = misr_rst_q;
    pass       = pass_q;
    mismatch_a = mismatch_a_q;
    mismatch_b = mismatch_b_q;
    err_seen   = err_seen_q;
    escape     = escape_q;
    fail_cnt   = fail_cnt_q;
    esc_cnt    = esc_cnt_q;
  end

endmodule

// File: tb/tb_misr_sig_checker.sv
// Table-driven bench for misr_sig_checker with a scoreboard queue of expected run results.
module tb_misr_sig_checker;

  localparam int WIN = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] sig_a, sig_b;
  logic       inj_flag;
  logic       misr_rst, busy, done, pass, mismatch_a, mismatch_b, err_seen, escape;
  logic [7:0] fail_cnt, esc_cnt;

  misr_sig_checker #(
    .SIG_W (3),
    .WINDOW(WIN),
    .GOLD_A(3'b001),
    .GOLD_B(3'b100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sig_a     (sig_a),
    .sig_b     (sig_b),
    .inj_flag  (inj_flag),
    .misr_rst  (misr_rst),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .mismatch_a(mismatch_a),
    .mismatch_b(mismatch_b),
    .err_seen  (err_seen),
    .escape    (escape),
    .fail_cnt  (fail_cnt),
    .esc_cnt   (esc_cnt)
  );

  always #5 clk = ~clk;

  // inj bit 0 = SEED cycle, bits 1..WIN = RUN cycles, bit WIN+1 = CHECK cycle.
  typedef struct {
    logic [7:0] inj;
    logic [2:0] sa;
    logic [2:0] sb;
    logic       ma;
    logic       mb;
    logic       err;
    logic       ps;
    logic       esc;
  } vec_t;

  typedef struct {
    logic       ma;
    logic       mb;
    logic       err;
    logic       ps;
    logic       esc;
    logic [7:0] fc;
    logic [7:0] ec;
  } exp_t;

  vec_t vecs[7];
  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_fail = 0;
  int   m_esc  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_misr_rst"}, 32'(misr_rst), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_mis_a"}, 32'(mismatch_a), 0);
    check({tag, "_mis_b"}, 32'(mismatch_b), 0);
    check({tag, "_err"}, 32'(err_seen), 0);
    check({tag, "_esc"}, 32'(escape), 0);
    check({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
    check({tag, "_esc_cnt"}, 32'(esc_cnt), 0);
  endtask

  // Call at a negedge; start is sampled at the following posedge.
  task automatic run_one(input vec_t v, input bit hold, input string tag);
    exp_t e, got;
    int   rst_cycles = 0;
    bit   seen = 0;
    start = 1'b1;
    for (int k = 1; k <= WIN + 10 && !seen; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (misr_rst) rst_cycles++;
      if (k == 1) begin
        check({tag, "_seed_busy"}, 32'(busy), 1);
        check({tag, "_seed_pass_clr"}, 32'(pass), 0);
        check({tag, "_seed_err_clr"}, 32'(err_seen), 0);
      end
      if (done && k > 1) begin
        seen = 1;
        check({tag, "_latency"}, 32'(k), 32'(WIN + 3));
        check({tag, "_done_busy"}, 32'(busy), 0);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL %s_sb_empty: got done expected no result pending", tag);
        end else begin
          got = sb_q.pop_front();
          check({tag, "_mis_a"}, 32'(mismatch_a), 32'(got.ma));
          check({tag, "_mis_b"}, 32'(mismatch_b), 32'(got.mb));
          check({tag, "_err"}, 32'(err_seen), 32'(got.err));
          check({tag, "_pass"}, 32'(pass), 32'(got.ps));
          check({tag, "_esc"}, 32'(escape), 32'(got.esc));
          check({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(got.fc));
          check({tag, "_esc_cnt"}, 32'(esc_cnt), 32'(got.ec));
        end
      end else begin
        inj_flag = (k <= WIN + 2) ? v.inj[k-1] : 1'b0;
        sig_a    = (k == WIN + 2) ? v.sa : ~v.sa;
        sig_b    = (k == WIN + 2) ? v.sb : ~v.sb;
        if (k == WIN + 2) begin
          if (!v.ps) m_fail = (m_fail < 255) ? m_fail + 1 : 255;
          if (v.esc) m_esc = (m_esc < 255) ? m_esc + 1 : 255;
          e = '{ma: v.ma, mb: v.mb, err: v.err, ps: v.ps, esc: v.esc,
                fc: 8'(m_fail), ec: 8'(m_esc)};
          sb_q.push_back(e);
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done after %0d cycles", tag, WIN + 3);
    end
    check({tag, "_misr_rst_cycles"}, 32'(rst_cycles), 1);
    inj_flag = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{inj: 8'h00, sa: 3'b001, sb: 3'b100, ma: 0, mb: 0, err: 0, ps: 1, esc: 0};
    vecs[1] = '{inj: 8'h04, sa: 3'b110, sb: 3'b100, ma: 1, mb: 0, err: 1, ps: 0, esc: 0};
    vecs[2] = '{inj: 8'h08, sa: 3'b001, sb: 3'b100, ma: 0, mb: 0, err: 1, ps: 1, esc: 1};
    vecs[3] = '{inj: 8'h40, sa: 3'b001, sb: 3'b100, ma: 0, mb: 0, err: 0, ps: 1, esc: 0};
    vecs[4] = '{inj: 8'h01, sa: 3'b001, sb: 3'b000, ma: 0, mb: 1, err: 1, ps: 0, esc: 0};
    vecs[5] = '{inj: 8'h20, sa: 3'b000, sb: 3'b011, ma: 1, mb: 1, err: 1, ps: 0, esc: 0};
    vecs[6] = '{inj: 8'h00, sa: 3'b101, sb: 3'b100, ma: 1, mb: 0, err: 0, ps: 0, esc: 0};

    rst = 1'b1; start = 1'b0; inj_flag = 1'b0; sig_a = '0; sig_b = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // Vector 2 holds start through RUN (ignored) and DONE (back-to-back into vector 3).
    for (int i = 0; i < 7; i++) run_one(vecs[i], (i == 2), $sformatf("vec%0d", i));

    // Reset in the fourth RUN cycle must abandon the run and clear the counters.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("midrun_rst");
    m_fail = 0;
    m_esc  = 0;
    run_one(vecs[0], 1'b0, "post_rst");

    for (int i = 0; i < 256; i++) run_one(vecs[6], 1'b0, $sformatf("sat%0d", i));
    check("sat_final", 32'(fail_cnt), 32'hFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("sat_rst");

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/misr_sig_checker.md
# misr_sig_checker

Downstream signature checker for the paper-example error-injection circuit. It sequences one self-test window: it seeds both MISRs through `misr_rst`, lets them compact for `WINDOW` cycles, then compares the two captured signatures against golden values. Each run is classified as pass, detected or escaped, where escaped means an injected error left both signatures matching the golden values. The block drives the MISR reset input `m_rst` and consumes the two MISR states and the sticky `inj_error` flag.

## Interface
Parameters:
- `SIG_W`, 3: width of each MISR signature.
- `WINDOW`, 5: number of compaction cycles per run, legal range 1..255.
- `GOLD_A`, 3'b001: expected final value of signature A.
- `GOLD_B`, 3'b100: expected final value of signature B.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a run; sampled only in IDLE or DONE.
- `sig_a`  in  SIG_W: current state of the first MISR.
- `sig_b`  in  SIG_W: current state of the second MISR.
- `inj_flag`  in  1: upstream error-injected indication.
- `misr_rst`  out  1: seed pulse to both MISRs; registered.
- `busy`  out  1: high in SEED, RUN and CHECK.
- `done`  out  1: high in DONE.
- `pass`  out  1: both signatures matched golden; valid while `done`.
- `mismatch_a`  out  1: `sig_a` differed from `GOLD_A`; valid while `done`.
- `mismatch_b`  out  1: `sig_b` differed from `GOLD_B`; valid while `done`.
- `err_seen`  out  1: `inj_flag` was high during SEED or RUN; valid while `done`.
- `escape`  out  1: `err_seen && pass`; valid while `done`.
- `fail_cnt`  out  8: saturating count of runs with `pass=0`.
- `esc_cnt`  out  8: saturating count of runs with `escape=1`.

## Operation
- States are IDLE, SEED, RUN, CHECK and DONE; the state is one-hot or encoded, implementer's choice.
- IDLE: when `start=1`, go to SEED; otherwise stay.
- SEED: lasts exactly 1 cycle.
  - `misr_rst=1` in this state only.
  - Clear `cyc_cnt`, `err_seen` and the per-run result flags.
  - Go to RUN.
- RUN: lasts exactly `WINDOW` cycles.
  - `cyc_cnt` counts 0..WINDOW-1.
  - At `cyc_cnt==WINDOW-1`, go to CHECK.
- CHECK: lasts 1 cycle.
  - Register `mismatch_a = (sig_a != GOLD_A)` and `mismatch_b = (sig_b != GOLD_B)`.
  - Register `pass`, and `escape = err_seen && pass`.
  - Update the counters.
  - Go to DONE.
- DONE: hold all results.
  - When `start=1`, go to SEED, which clears the previous results.
  - Otherwise stay.
- `err_seen` is a sticky OR of `inj_flag` sampled in SEED and in every RUN cycle. `inj_flag` in CHECK is ignored.
- `fail_cnt` and `esc_cnt` each increment by 1 in CHECK when their condition holds, and saturate at 8'hFF. They are not cleared by `start`, only by `rst`.
- `start` in SEED, RUN or CHECK is ignored and is not queued.
- Signature comparison is bitwise over all `SIG_W` bits. X or Z on the signature inputs is not handled.

## Timing
- Reset (`rst=1` at an edge) takes priority over everything, including mid-run.
  - Next state is IDLE.
  - `misr_rst`, `busy`, `done`, `pass`, `mismatch_a`, `mismatch_b`, `err_seen` and `escape` are 0.
  - `fail_cnt` and `esc_cnt` are 0.
- `start` sampled high at edge t gives SEED in cycle t+1, with `misr_rst=1` and `busy=1`.
- The MISRs load their seed at the edge ending SEED.
- RUN occupies cycles t+2 .. t+1+WINDOW, so the MISRs perform exactly `WINDOW` compaction updates.
- CHECK is in cycle t+2+WINDOW and samples `sig_a`/`sig_b` combinationally in that cycle.
- `done=1` with valid results from cycle t+3+WINDOW. Start-to-done latency is `WINDOW+3` cycles.
- Back-to-back runs: `start` held high in DONE re-enters SEED on the next cycle. `done` is low for `WINDOW+2` cycles between runs.
- `WINDOW=1`: RUN lasts a single cycle; there is no zero-length run.
- Counter wrap: `cyc_cnt` is 8 bits and never wraps, because RUN exits at `WINDOW-1`.

## Test plan
- Golden run, default parameters: pulse `start`; drive `sig_a=3'b001`, `sig_b=3'b100` in CHECK with `inj_flag=0` → `misr_rst` high exactly 1 cycle; `done` rises 8 cycles after `start`; `pass=1`, `escape=0`, `fail_cnt=0`.
- Detected fault: `inj_flag=1` in RUN cycle 2; `sig_a=3'b110`, `sig_b=3'b100` in CHECK → `mismatch_a=1`, `mismatch_b=0`, `pass=0`, `err_seen=1`, `escape=0`, `fail_cnt=1`.
- Escaped fault: `inj_flag=1` in RUN; both signatures golden in CHECK → `pass=1`, `err_seen=1`, `escape=1`, `esc_cnt=1`.
- Reset mid-run: assert `rst` in RUN cycle 3 → next cycle IDLE with all outputs and counters 0; a later `start` completes a normal run.
- Ignored start and back-to-back: pulse `start` during RUN → no restart, `done` timing unchanged. Hold `start` high in DONE → SEED follows immediately and the results clear.
- Saturation: 256 consecutive failing runs → `fail_cnt` stops at 8'hFF; `rst` returns it to 0.
